// File: rtl/alu_op_sequencer.sv
// Multi-cycle command sequencer for the 4-bit ALU datapath.
// Single-cycle ops resolve on acceptance; MUL/DIV iterate four times in EXEC.
module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOTA = 4'd7,
        OP_NOTB = 4'd8
    } op_t;

    state_t     state, state_n;
    logic [3:0] op_q, a_q, b_q;
    logic [7:0] acc, acc_n;
    logic [1:0] cnt, cnt_n;
    logic [7:0] res_n;
    logic       err_n;
    logic       accept;
    logic [4:0] trial, diff;

    assign accept = req_valid && req_ready;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        res_n   = rsp_result;
        err_n   = rsp_err;
        trial   = '0;
        diff    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = DONE;
                    err_n   = 1'b0;
                    case (req_op)
                        OP_ADD:  res_n = {4'h0, req_a} + {4'h0, req_b};
                        OP_SUB:  res_n = {4'h0, req_a} - {4'h0, req_b};
                        OP_MUL: begin
                            acc_n   = '0;
                            cnt_n   = '0;
                            state_n = EXEC;
                        end
                        OP_DIV: begin
                            if (req_b == 4'h0) begin
                                res_n = {req_a, 4'hF};
                                err_n = 1'b1;
                            end else begin
                                acc_n   = '0;
                                cnt_n   = '0;
                                state_n = EXEC;
                            end
                        end
                        OP_AND:  res_n = {4'h0, req_a & req_b};
                        OP_OR:   res_n = {4'h0, req_a | req_b};
                        OP_XOR:  res_n = {4'h0, req_a ^ req_b};
                        OP_NOTA: res_n = {4'h0, ~req_a};
                        OP_NOTB: res_n = {4'h0, ~req_b};
                        default: begin
                            res_n = '0;
                            err_n = 1'b1;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (op_q == OP_MUL) begin
                    if (b_q[cnt])
                        acc_n = acc + ({4'h0, a_q} << cnt);
                end else begin
                    // acc holds {remainder, quotient}; quotient bits shift in from the LSB
                    trial = {acc[7:4], a_q[2'd3 - cnt]};
                    if (trial >= {1'b0, b_q}) begin
                        diff  = trial - {1'b0, b_q};
                        acc_n = {diff[3:0], acc[2:0], 1'b1};
                    end else begin
                        acc_n = {trial[3:0], acc[2:0], 1'b0};
                    end
                end
                cnt_n = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    res_n   = acc_n;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (rsp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            cnt        <= cnt_n;
            rsp_result <= res_n;
            rsp_err    <= err_n;
            rsp_valid  <= (state_n == DONE);
            req_ready  <= (state_n == IDLE);
            busy       <= (state_n != IDLE);
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, hand sequences for
// backpressure and mid-op reset, then random ops against an arithmetic model.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: {err, result} from plain arithmetic.
    function automatic logic [8:0] model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int ai, bi, r;
        ai = a;
        bi = b;
        case (op)
            4'd0: r = ai + bi;
            4'd1: r = (ai - bi + 256) % 256;
            4'd2: r = ai * bi;
            4'd3: begin
                if (bi == 0) return {1'b1, a, 4'hF};
                r = (ai % bi) * 16 + ai / bi;
            end
            4'd4: r = ai & bi;
            4'd5: r = ai | bi;
            4'd6: r = ai ^ bi;
            4'd7: r = 15 - ai;
            4'd8: r = 15 - bi;
            default: return 9'h100;
        endcase
        return {1'b0, 8'(r)};
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [3:0] b);
        if (op == 4'd2 || (op == 4'd3 && b != 4'h0)) return 5;
        return 1;
    endfunction

    // One transaction; bp = cycles rsp_ready stays low after rsp_valid.
    // spurious drives an extra request while the response is backpressured.
    task automatic do_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] er, input logic ee, input int el,
                         input int bp, input bit spurious, input string tag);
        int  lat;
        bit  got;
        @(negedge clk);
        check({tag, " req_ready idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = (bp == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = 4'($urandom);
        req_b     = 4'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            check({tag, " busy"}, busy, 1);
            if (rsp_valid) got = 1'b1;
            else check({tag, " req_ready low"}, req_ready, 0);
        end
        check({tag, " latency"}, lat, el);
        if (!got) return;
        check({tag, " result"}, rsp_result, er);
        check({tag, " err"}, rsp_err, ee);
        for (int i = 0; i < bp; i++) begin
            if (spurious) begin
                req_valid = 1'b1;
                req_op    = 4'd0;
                req_a     = 4'h1;
                req_b     = 4'h1;
            end
            @(negedge clk);
            check({tag, " held valid"}, rsp_valid, 1);
            check({tag, " held result"}, rsp_result, er);
            check({tag, " held err"}, rsp_err, ee);
            check({tag, " held req_ready"}, req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, " valid cleared"}, rsp_valid, 0);
        check({tag, " req_ready back"}, req_ready, 1);
        check({tag, " busy cleared"}, busy, 0);
    endtask

    initial begin
        logic [3:0] op, a, b;
        logic [8:0] m;
        int         bp;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        vecs.push_back('{4'd0, 4'hA, 4'hF, 8'h19, 1'b0, 1});
        vecs.push_back('{4'd1, 4'hA, 4'hF, 8'hFB, 1'b0, 1});
        vecs.push_back('{4'd2, 4'hA, 4'hF, 8'h96, 1'b0, 5});
        vecs.push_back('{4'd2, 4'hF, 4'hF, 8'hE1, 1'b0, 5});
        vecs.push_back('{4'd2, 4'h7, 4'h0, 8'h00, 1'b0, 5});
        vecs.push_back('{4'd3, 4'hA, 4'hF, 8'hA0, 1'b0, 5});
        vecs.push_back('{4'd3, 4'hF, 4'h4, 8'h33, 1'b0, 5});
        vecs.push_back('{4'd3, 4'hF, 4'h1, 8'h0F, 1'b0, 5});
        vecs.push_back('{4'd3, 4'hA, 4'h0, 8'hAF, 1'b1, 1});
        vecs.push_back('{4'd4, 4'hA, 4'hF, 8'h0A, 1'b0, 1});
        vecs.push_back('{4'd5, 4'hA, 4'hF, 8'h0F, 1'b0, 1});
        vecs.push_back('{4'd6, 4'hA, 4'hF, 8'h05, 1'b0, 1});
        vecs.push_back('{4'd7, 4'hA, 4'hF, 8'h05, 1'b0, 1});
        vecs.push_back('{4'd8, 4'hA, 4'hF, 8'h00, 1'b0, 1});
        vecs.push_back('{4'hC, 4'hA, 4'hF, 8'h00, 1'b1, 1});
        vecs.push_back('{4'h9, 4'h3, 4'h3, 8'h00, 1'b1, 1});
        vecs.push_back('{4'hF, 4'h3, 4'h3, 8'h00, 1'b1, 1});

        #12;
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_result", rsp_result, 8'h00);
        check("reset rsp_err", rsp_err, 0);
        check("reset busy", busy, 0);
        check("reset req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err,
                  vecs[i].lat, 0, 1'b0, $sformatf("vec%0d", i));

        do_op(4'd2, 4'h3, 4'h5, 8'h0F, 1'b0, 5, 3, 1'b1, "backpressure");

        // Reset in the second EXEC cycle of a divide.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd3;
        req_a     = 4'hF;
        req_b     = 4'h4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset rsp_valid", rsp_valid, 0);
        check("midreset rsp_result", rsp_result, 8'h00);
        check("midreset rsp_err", rsp_err, 0);
        check("midreset busy", busy, 0);
        check("midreset req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midreset no response", rsp_valid, 0);
        end
        do_op(4'd0, 4'h1, 4'h1, 8'h02, 1'b0, 1, 0, 1'b0, "post-reset add");

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 4'($urandom);
            b  = 4'($urandom);
            bp = $urandom_range(0, 2);
            m  = model(op, a, b);
            do_op(op, a, b, m[7:0], m[8], model_lat(op, b), bp, 1'b0,
                  $sformatf("rand%0d op%0h a%0h b%0h", i, op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
